// File: rtl/inv_sub_bytes_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : inv_sub_bytes_seq_if
//  Brief    : Handshake, data and S-box lane bundle for inv_sub_bytes_seq.
//  Revision : 1.0  initial release
// ============================================================================
interface inv_sub_bytes_seq_if #(
   parameter int LANES = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [127:0]         in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [127:0]         out_data;
   logic [8*LANES-1:0]   sbox_in;
   logic [8*LANES-1:0]   sbox_out;
   logic                 busy;

   modport master (
      output in_valid, in_data, out_ready, sbox_out,
      input  in_ready, out_valid, out_data, sbox_in, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready, sbox_out,
      output in_ready, out_valid, out_data, sbox_in, busy
   );
endinterface
`default_nettype wire

// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
//  Module   : inv_sub_bytes_seq
//  Brief    : AES InvSubBytes over a 128-bit state, LANES bytes per cycle
//             through an external shared inverse S-box lane.
//  Revision : 1.0  initial release
// ============================================================================
module inv_sub_bytes_seq #(
   parameter int LANES = 4
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   inv_sub_bytes_seq_if.slave bus
);
   localparam int BEATS = 16 / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LW    = 8 * LANES;

   localparam logic [1:0]    c_IDLE = 2'd0;
   localparam logic [1:0]    c_SUB  = 2'd1;
   localparam logic [1:0]    c_DONE = 2'd2;
   localparam logic [CW-1:0] c_LAST = CW'(BEATS - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [127:0]  src_q, src_d;
   logic [127:0]  res_q, res_d;
   logic [LW-1:0] w_lane;
   logic          w_in_ready;

   assign w_in_ready = rst_n && (state_q == c_IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      res_d   = res_q;
      w_lane  = '0;
      // Beat b owns bytes [b*LANES .. b*LANES+LANES-1] of both registers.
      for (int b = 0; b < BEATS; b++) begin
         if (cnt_q == CW'(b)) begin
            w_lane = src_q[b*LW +: LW];
         end
      end
      case (state_q)
         c_IDLE: begin
            if (bus.in_valid && w_in_ready) begin
               src_d   = bus.in_data;
               cnt_d   = '0;
               state_d = c_SUB;
            end
         end
         c_SUB: begin
            for (int b = 0; b < BEATS; b++) begin
               if (cnt_q == CW'(b)) begin
                  res_d[b*LW +: LW] = bus.sbox_out;
               end
            end
            if (cnt_q == c_LAST) begin
               state_d = c_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         c_DONE: begin
            if (bus.out_ready) begin
               cnt_d   = '0;
               state_d = c_IDLE;
            end
         end
         default: begin
            state_d = c_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= c_IDLE;
         cnt_q   <= '0;
         src_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         res_q   <= res_d;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (state_q == c_DONE);
   assign bus.out_data  = res_q;
   assign bus.sbox_in   = (state_q == c_SUB) ? w_lane : '0;
   assign bus.busy      = (state_q != c_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_sub_bytes_seq
//  Brief    : Self-checking bench; one DUT per legal LANES value, each fed by
//             a GF(2^8)-derived inverse S-box lane model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inv_sub_bytes_seq;
   localparam int NDUT = 5;
   localparam int NBLK = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NDUT-1:0] in_valid_a;
   logic [NDUT-1:0] out_ready_a;
   logic [127:0]    in_data_a [NDUT];
   wire  [NDUT-1:0] in_ready_w;
   wire  [NDUT-1:0] out_valid_w;
   wire  [NDUT-1:0] busy_w;
   wire  [127:0]    out_data_w [NDUT];
   wire  [127:0]    sbox_in_w  [NDUT];

   logic [7:0] inv_sb [256];
   int total = 0;
   int bad   = 0;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      localparam int L = 1 << k;
      inv_sub_bytes_seq_if #(.LANES(L)) u_if ();
      assign u_if.in_valid  = in_valid_a[k];
      assign u_if.in_data   = in_data_a[k];
      assign u_if.out_ready = out_ready_a[k];
      assign in_ready_w[k]  = u_if.in_ready;
      assign out_valid_w[k] = u_if.out_valid;
      assign busy_w[k]      = u_if.busy;
      assign out_data_w[k]  = u_if.out_data;
      assign sbox_in_w[k]   = 128'(u_if.sbox_in);
      always_comb begin
         u_if.sbox_out = '0;
         for (int i = 0; i < L; i++) begin
            u_if.sbox_out[8*i +: 8] = inv_sb[u_if.sbox_in[8*i +: 8]];
         end
      end
      inv_sub_bytes_seq #(.LANES(L)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (u_if)
      );
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // Forward S-box = GF inverse + affine map; the inverse table is its preimage.
   task automatic build_inv_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] iv = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
         end
         s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
         inv_sb[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] ref_sub(input logic [127:0] d);
      logic [127:0] r;
      for (int j = 0; j < 16; j++) r[8*j +: 8] = inv_sb[d[8*j +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic run_block(input int k, input logic [127:0] d, input logic [127:0] e, input string nm);
      int n;
      int beats = 16 >> k;
      in_data_a[k]  = d;
      in_valid_a[k] = 1'b1;
      n = 0;
      while (!in_ready_w[k] && n < 50) begin tick(); n++; end
      chk($sformatf("%s_ready L=%0d", nm, 1 << k), 128'(in_ready_w[k]), 128'd1);
      tick();
      in_valid_a[k] = 1'b0;
      in_data_a[k]  = ~d;
      n = 0;
      while (!out_valid_w[k] && n < 100) begin tick(); n++; end
      chk($sformatf("%s_latency L=%0d", nm, 1 << k), 128'(n), 128'(beats));
      chk($sformatf("%s_data L=%0d", nm, 1 << k), out_data_w[k], e);
      tick();
      chk($sformatf("%s_idle L=%0d", nm, 1 << k),
          {126'd0, out_valid_w[k], in_ready_w[k]}, 128'd1);
   endtask

   task automatic sub_trace(input int k);
      int L = 1 << k;
      int beats = 16 >> k;
      logic [127:0] cap = rnd128();
      logic [127:0] mask = (k == 4) ? '1 : ((128'd1 << (8 * L)) - 128'd1);
      in_data_a[k]  = cap;
      in_valid_a[k] = 1'b1;
      chk($sformatf("trace_ready L=%0d", L), 128'(in_ready_w[k]), 128'd1);
      tick();
      in_valid_a[k] = 1'b0;
      for (int b = 0; b < beats; b++) begin
         chk($sformatf("trace_lane L=%0d beat=%0d", L, b), sbox_in_w[k], (cap >> (b * 8 * L)) & mask);
         in_data_a[k] = rnd128();
         tick();
      end
      chk($sformatf("trace_valid L=%0d", L), 128'(out_valid_w[k]), 128'd1);
      chk($sformatf("trace_data L=%0d", L), out_data_w[k], ref_sub(cap));
      chk($sformatf("trace_lane_done L=%0d", L), sbox_in_w[k], 128'd0);
      tick();
   endtask

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
      string        nm;
   } vec_t;

   vec_t         vecs [4];
   logic [127:0] sq [NDUT][$];
   int           acc_n [NDUT];
   int           out_n [NDUT];
   int           last_acc [NDUT];

   initial begin
      logic [127:0] d1, d2, held;
      logic [NDUT-1:0] acc, dq;
      int guard;
      bit all_done;
      bit seen;

      vecs[0] = '{128'h00000000_00000000_00000076_894de193,
                  128'h52525252_52525252_5252520f_f265e022, "known5"};
      vecs[1] = '{{16{8'h63}}, 128'd0, "all63"};
      vecs[2] = '{128'h0f0e0d0c_0b0a0908_07060504_03020100,
                  128'hfbd7f381_9ea340bf_38a53630_d56a0952, "ramp"};
      vecs[3] = '{128'd0, {16{8'h52}}, "zeros"};

      in_valid_a  = '0;
      out_ready_a = '1;
      for (int k = 0; k < NDUT; k++) in_data_a[k] = 128'd0;
      build_inv_sbox();

      rst_n = 1'b0;
      tick();
      tick();
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("reset_flags L=%0d", 1 << k),
             {125'd0, in_ready_w[k], out_valid_w[k], busy_w[k]}, 128'd0);
         chk($sformatf("reset_lane L=%0d", 1 << k), sbox_in_w[k], 128'd0);
      end
      rst_n = 1'b1;
      #1;
      chk("reset_release_ready", 128'(in_ready_w[2]), 128'd1);

      for (int v = 0; v < 4; v++)
         for (int k = 0; k < NDUT; k++)
            run_block(k, vecs[v].din, vecs[v].dout, vecs[v].nm);

      // Backpressure on the LANES=4 instance.
      d1 = rnd128();
      out_ready_a[2] = 1'b0;
      in_data_a[2]   = d1;
      in_valid_a[2]  = 1'b1;
      tick();
      in_valid_a[2] = 1'b0;
      guard = 0;
      while (!out_valid_w[2] && guard < 50) begin tick(); guard++; end
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("bp_data c=%0d", c), out_data_w[2], ref_sub(d1));
         chk($sformatf("bp_flags c=%0d", c), {126'd0, out_valid_w[2], in_ready_w[2]}, 128'd2);
         in_valid_a[2] = c[0];
         in_data_a[2]  = rnd128();
         tick();
      end
      in_valid_a[2]  = 1'b0;
      out_ready_a[2] = 1'b1;
      tick();
      chk("bp_release", {125'd0, in_ready_w[2], out_valid_w[2], busy_w[2]}, 128'd4);

      sub_trace(2);
      sub_trace(0);
      sub_trace(3);

      // Reset while the beat counter sits at 2.
      d1 = rnd128();
      in_data_a[2]  = d1;
      in_valid_a[2] = 1'b1;
      tick();
      in_valid_a[2] = 1'b0;
      tick();
      tick();
      chk("midreset_lane_beat2", sbox_in_w[2], (d1 >> 64) & 128'hffff_ffff);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("midreset_flags", {125'd0, in_ready_w[2], out_valid_w[2], busy_w[2]}, 128'd4);
      chk("midreset_lane", sbox_in_w[2], 128'd0);
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (out_valid_w[2]) seen = 1'b1;
      end
      chk("midreset_no_output", 128'(seen), 128'd0);
      d2 = rnd128();
      run_block(2, d2, ref_sub(d2), "post_reset");

      // Back-to-back random traffic on every instance.
      for (int k = 0; k < NDUT; k++) begin
         acc_n[k] = 0;
         out_n[k] = 0;
         last_acc[k] = 0;
         in_data_a[k] = rnd128();
      end
      in_valid_a  = '1;
      out_ready_a = '1;
      guard = 0;
      all_done = 1'b0;
      while (guard < 2500 && !all_done) begin
         for (int k = 0; k < NDUT; k++) begin
            acc[k] = in_valid_a[k] & in_ready_w[k];
            dq[k]  = out_valid_w[k] & out_ready_a[k];
            if (acc[k]) begin
               sq[k].push_back(in_data_a[k]);
               if (acc_n[k] > 0)
                  chk($sformatf("b2b_interval L=%0d", 1 << k),
                      128'(guard - last_acc[k]), 128'((16 >> k) + 2));
               last_acc[k] = guard;
               acc_n[k]++;
            end
            if (dq[k]) begin
               if (sq[k].size() > 0) begin
                  held = sq[k].pop_front();
                  chk($sformatf("b2b_data L=%0d n=%0d", 1 << k, out_n[k]), out_data_w[k], ref_sub(held));
               end else begin
                  chk($sformatf("b2b_spurious L=%0d", 1 << k), 128'(out_valid_w[k]), 128'd0);
               end
               out_n[k]++;
            end
         end
         tick();
         guard++;
         all_done = 1'b1;
         for (int k = 0; k < NDUT; k++) begin
            if (acc[k]) begin
               in_data_a[k] = rnd128();
               if (acc_n[k] == NBLK) in_valid_a[k] = 1'b0;
            end
            if (out_n[k] < NBLK) all_done = 1'b0;
         end
      end
      for (int k = 0; k < NDUT; k++)
         chk($sformatf("b2b_count L=%0d", 1 << k), 128'(out_n[k]), 128'(NBLK));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Sequencer that runs the AES InvSubBytes step on a 128-bit state through a narrow, shared inverse S-box lane.
- Processes LANES bytes per cycle instead of 16 parallel lookups, trading latency for area in the decrypt round datapath.
- Sits between the InvShiftRows output register and the AddRoundKey stage.
- Drives an external combinational lookup lane of LANES inverse S-box instances, and talks to neighbours with valid/ready handshakes.

Parameters:
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
- BEATS, 16/LANES, derived localparam, cycles per block; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  in_data holds a state to substitute.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  128  input state; byte k = bits [8k+7:8k].
- out_valid  output  1  out_data holds a finished substituted state.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  128  substituted state; byte k = InvSbox(in byte k).
- sbox_in  output  8*LANES  bytes presented to the shared lookup lane.
- sbox_out  input  8*LANES  lane results; lane i = InvSbox(sbox_in lane i), combinational, same cycle.
- busy  output  1  high in SUB or DONE.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, beat counter=0, source and result registers=0, in_ready=0 while in reset, out_valid=0, busy=0. sbox_in=0.
- Reset mid-operation discards the block in flight; no out_valid is produced for it.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_data into src_reg, set cnt=0, go to SUB.
- SUB:
  - in_ready=0.
  - sbox_in = src_reg bytes [cnt*LANES .. cnt*LANES+LANES-1], lane i = byte cnt*LANES+i.
  - Each edge: write sbox_out into the same byte positions of res_reg, then cnt++.
  - When cnt==BEATS-1, that write completes the block and the FSM goes to DONE.
  - With LANES=16 (BEATS=1), SUB lasts exactly one cycle.
- DONE:
  - out_valid=1; out_data=res_reg, held stable until accepted.
  - On out_ready: go to IDLE and clear out_valid.
  - out_ready while out_valid=0 is ignored.
- sbox_in=0 outside SUB. Lookup results are used only in SUB.
- Latency: input accepted at edge T; out_valid=1 after edge T+BEATS (first visible cycle T+BEATS+1 counting the accept cycle as T).
- Throughput: one block per BEATS+2 cycles minimum; no overlap, since in_ready=0 in SUB and DONE.
- in_data is sampled only on handshake; changes to in_data during SUB do not affect the result.
- cnt width is clog2(BEATS), min 1 bit. cnt wraps to 0 only through the IDLE entry; it never exceeds BEATS-1.
- Backpressure: DONE may persist indefinitely; res_reg and out_data stay constant throughout.
- busy = (state != IDLE).

Test Plan:
1. Reset then single block, LANES=4: low bytes 0x93,0xE1,0x4D,0x89,0x76 (upper bytes 0x00), out_ready=1 -> out_valid exactly 4 cycles after accept; same byte positions = 0x22,0xE0,0x65,0xF2,0x0F; upper bytes=0x52.
2. All-0x63 input -> out_data all 0x00. Byte pattern k -> out byte k = InvSbox[k] for k=0..15, checked against a bench lookup model on the lane. Re-run with LANES=1, 2, 8, 16: latency = 16, 8, 2, 1 cycles.
3. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> next cycle IDLE, in_ready=1.
4. in_data toggled randomly during SUB -> result matches the captured value only; sbox_in lane order matches beat/byte mapping each cycle.
5. rst_n low for one edge at cnt=2 -> next cycle state IDLE, out_valid=0, busy=0. A new block then completes correctly with no stale bytes.
6. Back-to-back: in_valid held high with out_ready=1 -> accepts every BEATS+2 cycles; 100 random states all match the model.
